// File: rtl/ula_seq_if.sv
// ula_seq_if: command, response and ULA drive bundle for the ULA sequencing controller.
interface ula_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_s;
   logic        cmd_m;
   logic        cmd_c_in;
   logic        cmd_wide;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [7:0]  ula_a;
   logic [7:0]  ula_b;
   logic [3:0]  ula_s;
   logic        ula_m;
   logic        ula_c_in;
   logic [7:0]  ula_f;
   logic        ula_c_out;
   logic        ula_overflow;
   logic        ula_a_eq_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_f;
   logic        rsp_c_out;
   logic        rsp_overflow;
   logic        rsp_a_eq_b;

   modport master (
      output cmd_valid, cmd_s, cmd_m, cmd_c_in, cmd_wide, cmd_a, cmd_b,
      input  cmd_ready,
      input  ula_a, ula_b, ula_s, ula_m, ula_c_in,
      output ula_f, ula_c_out, ula_overflow, ula_a_eq_b,
      input  rsp_valid, rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_s, cmd_m, cmd_c_in, cmd_wide, cmd_a, cmd_b,
      output cmd_ready,
      output ula_a, ula_b, ula_s, ula_m, ula_c_in,
      input  ula_f, ula_c_out, ula_overflow, ula_a_eq_b,
      output rsp_valid, rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b,
      input  rsp_ready
   );
endinterface

// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: runs one (8-bit) or two (16-bit, carry-chained) passes through an 8-bit ULA per command.
module ula_seq_ctrl #(
   parameter int WAIT_CYC = 1
) (
   input logic     clk,
   input logic     rst_n,
   ula_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [3:0] WC = 4'(WAIT_CYC);

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [3:0]  s;
   logic        m, c_in, wide;
   logic [15:0] a, b;
   logic [15:0] f;
   logic        c_out, ovf, eq;
   logic        busy, accept, capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      busy     = state == LO || state == HI;
      accept   = bus.cmd_valid && state == IDLE;
      capture  = busy && cnt == WC;
      state_nx = state;
      if (accept) state_nx = LO;
      if (capture) state_nx = (state == LO && wide) ? HI : DONE;
      if (state == DONE && bus.rsp_ready) state_nx = IDLE;
      bus.cmd_ready = state == IDLE;
      bus.rsp_valid = state == DONE;
      bus.ula_a     = state == LO ? a[7:0] : state == HI ? a[15:8] : 8'h00;
      bus.ula_b     = state == LO ? b[7:0] : state == HI ? b[15:8] : 8'h00;
      bus.ula_s     = busy ? s : 4'h0;
      bus.ula_m     = busy && m;
      // the low-pass carry-out already sits in c_out while the high pass runs
      bus.ula_c_in  = state == LO ? c_in : state == HI && c_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         s     <= '0;
         m     <= 1'b0;
         c_in  <= 1'b0;
         wide  <= 1'b0;
         a     <= '0;
         b     <= '0;
         f     <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         eq    <= 1'b0;
      end else begin
         cnt <= (busy && !capture) ? cnt + 4'd1 : 4'd0;
         if (accept) begin
            s    <= bus.cmd_s;
            m    <= bus.cmd_m;
            c_in <= bus.cmd_c_in;
            wide <= bus.cmd_wide;
            a    <= bus.cmd_a;
            b    <= bus.cmd_b;
         end
         if (capture && state == LO) begin
            f     <= {8'h00, bus.ula_f};
            c_out <= bus.ula_c_out;
            ovf   <= bus.ula_overflow;
            eq    <= bus.ula_a_eq_b;
         end
         if (capture && state == HI) begin
            f[15:8] <= bus.ula_f;
            c_out   <= bus.ula_c_out;
            ovf     <= bus.ula_overflow;
            eq      <= eq & bus.ula_a_eq_b;
         end
      end
   end

   assign bus.rsp_f        = f;
   assign bus.rsp_c_out    = c_out;
   assign bus.rsp_overflow = ovf;
   assign bus.rsp_a_eq_b   = eq;
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// tb_ula_seq_ctrl: table-driven check of ula_seq_ctrl against a small behavioural ULA.
module tb_ula_seq_ctrl;
   localparam int WC = 1;

   typedef struct {
      logic [3:0]  s;
      logic        m, cin, wide;
      logic [15:0] a, b, f;
      logic        c, ov, eq, hic;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [8:0] sum;
   vec_t tv[10];

   ula_seq_if bus();

   ula_seq_ctrl #(.WAIT_CYC(WC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // ULA model: S=1001/M=0 add with carry, S=0110/M=1 xor, anything else passes A
   always_comb begin
      sum = {1'b0, bus.ula_a} + {1'b0, bus.ula_b} + {8'd0, bus.ula_c_in};
      bus.ula_a_eq_b   = bus.ula_a == bus.ula_b;
      bus.ula_f        = bus.ula_a;
      bus.ula_c_out    = 1'b0;
      bus.ula_overflow = 1'b0;
      if (!bus.ula_m && bus.ula_s == 4'b1001) begin
         bus.ula_f        = sum[7:0];
         bus.ula_c_out    = sum[8];
         bus.ula_overflow = bus.ula_a[7] == bus.ula_b[7] && sum[7] != bus.ula_a[7];
      end else if (bus.ula_m && bus.ula_s == 4'b0110) begin
         bus.ula_f = bus.ula_a ^ bus.ula_b;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.cmd_s    = v.s;
      bus.cmd_m    = v.m;
      bus.cmd_c_in = v.cin;
      bus.cmd_wide = v.wide;
      bus.cmd_a    = v.a;
      bus.cmd_b    = v.b;
   endtask

   task automatic send(input vec_t v, input bit keep);
      @(negedge clk);
      drive(v);
      bus.cmd_valid = 1'b1;
      chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = keep;
   endtask

   task automatic wait_rsp(input vec_t v, input string name);
      int k = 0;
      bit ok = 1'b1;
      while (!bus.rsp_valid && k < 40) begin
         if (bus.ula_s !== v.s || bus.ula_m !== v.m) ok = 1'b0;
         if (!((bus.ula_a === v.a[7:0] && bus.ula_b === v.b[7:0]) ||
               (v.wide && bus.ula_a === v.a[15:8] && bus.ula_b === v.b[15:8]))) ok = 1'b0;
         if (k == 0 && bus.ula_c_in !== v.cin) ok = 1'b0;
         if (v.wide && k == WC + 1) chk({name, "_hi_cin"}, 32'(bus.ula_c_in), 32'(v.hic));
         @(posedge clk);
         #1 k++;
      end
      chk({name, "_latency"}, 32'(k), 32'(v.lat));
      chk({name, "_drive"}, 32'(ok), 32'd1);
      chk({name, "_f"}, 32'(bus.rsp_f), 32'(v.f));
      chk({name, "_flags"}, 32'({bus.rsp_c_out, bus.rsp_overflow, bus.rsp_a_eq_b}),
          32'({v.c, v.ov, v.eq}));
   endtask

   task automatic ack();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({name, "_rsp"}, 32'({bus.rsp_f, bus.rsp_c_out, bus.rsp_overflow, bus.rsp_a_eq_b}), 32'd0);
      chk({name, "_ula"}, 32'({bus.ula_a, bus.ula_b, bus.ula_s, bus.ula_m, bus.ula_c_in}), 32'd0);
   endtask

   initial begin
      bit quiet;
      tv[0] = '{4'b1001, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      tv[1] = '{4'b1001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 4};
      tv[2] = '{4'b1001, 1'b0, 1'b0, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      tv[3] = '{4'b1001, 1'b0, 1'b0, 1'b0, 16'hAB7F, 16'hCD01, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      tv[4] = '{4'b0110, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
      tv[5] = '{4'b0110, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1334, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4};
      tv[6] = '{4'b1001, 1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      tv[7] = '{4'b1001, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4};
      tv[8] = '{4'b1001, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 4};
      tv[9] = '{4'b1001, 1'b0, 1'b0, 1'b1, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1'b0, 1'b0, 1'b0, 4};
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      drive(tv[0]);
      repeat (2) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(tv[i], 1'b0);
         wait_rsp(tv[i], $sformatf("v%0d", i));
         ack();
      end
      // backpressure with a second command waiting
      send(tv[0], 1'b1);
      drive(tv[2]);
      wait_rsp(tv[0], "bp_first");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_hold_rsp", 32'({bus.rsp_f, bus.rsp_c_out, bus.rsp_overflow, bus.rsp_a_eq_b}),
             32'({16'h0100, 3'b000}));
         chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      ack();
      @(posedge clk);
      #1 chk("bp_second_accept", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b0;
      wait_rsp(tv[2], "bp_second");
      ack();
      // reset pulse in the middle of the high pass
      send(tv[9], 1'b0);
      repeat (WC + 1) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_reset("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
      end
      chk("mid_reset_no_rsp", 32'(quiet), 32'd1);
      send(tv[9], 1'b0);
      wait_rsp(tv[9], "after_reset");
      ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
